// File: rtl/medfilt_pkg.sv
// Shared definitions for the median-filter frame-buffer writer.
//   IMG_COLS / IMG_ROWS : default image geometry
//   ADDR_W / PIX_W      : default frame-buffer address and pixel widths
//   FIFO_DEPTH          : default pixel FIFO depth
//   fsm_state_t         : writer FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
package medfilt_pkg;

    localparam int IMG_COLS   = 512;
    localparam int IMG_ROWS   = 512;
    localparam int ADDR_W     = 18;
    localparam int PIX_W      = 8;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/medfilt_fb_writer_pix_fifo.sv
// pix_fifo: synchronous FIFO holding {address, pixel} entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data this cycle (ignored when full and not popping)
//   push_data  : entry to store
//   pop        : remove the head this cycle (ignored when empty)
//   head       : current head entry (meaningful only when empty=0)
//   full/empty : occupancy flags
// Push and pop may happen in the same cycle, including while full.
module pix_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    import medfilt_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: only entries behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/medfilt_fb_writer.sv
// medfilt_fb_writer: writes the median filter's output pixels into a
// frame-buffer RAM write port in linear raster order (row*COLS+col).
//   CLK, RSTn       : clock, asynchronous active-low reset
//   Start_sig       : arms capture of one frame (honoured in IDLE only)
//   pix_valid_sig   : one-cycle pulse per filtered pixel, pix_data valid with it
//   wr_en/wr_addr/wr_data, wr_ready : RAM write port
//   busy_sig        : high in RUN or DRAIN
//   frame_done_sig  : one-cycle pulse once the last pixel has been written
//   overflow_sig    : sticky, a pixel was dropped on a full FIFO
//   salt_cnt/pepper_cnt : written all-ones / all-zero pixel counts
//   fsm_state       : current FSM state, for observation
// Build option: MEDFILT_NOISE_STAT_EN enables the salt/pepper counters;
// without it both counters are tied to 0.
//
// Write handshake: wr_en is high whenever an entry is pending, and a transfer
// happens on a rising edge where wr_en && wr_ready; while wr_en=1 and
// wr_ready=0, wr_addr and wr_data are held unchanged.
module medfilt_fb_writer #(
    parameter int COLS       = medfilt_pkg::IMG_COLS,
    parameter int ROWS       = medfilt_pkg::IMG_ROWS,
    parameter int ADDR_W     = medfilt_pkg::ADDR_W,
    parameter int PIX_W      = medfilt_pkg::PIX_W,
    parameter int FIFO_DEPTH = medfilt_pkg::FIFO_DEPTH
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start_sig,
    input  logic              pix_valid_sig,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              wr_ready,
    output logic              busy_sig,
    output logic              frame_done_sig,
    output logic              overflow_sig,
    output logic [ADDR_W-1:0] salt_cnt,
    output logic [ADDR_W-1:0] pepper_cnt,
    output logic [1:0]        fsm_state
);
    import medfilt_pkg::*;

    localparam int                ENTRY_W   = ADDR_W + PIX_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    fsm_state_t         state;
    fsm_state_t         state_nxt;
    logic [ADDR_W-1:0]  in_addr;
    logic               start_frame;
    logic               run_active;
    logic               accept_pix;
    logic               last_pix;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (Start_sig)              state_nxt = ST_RUN;
            ST_RUN:   if (accept_pix && last_pix) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)             state_nxt = ST_DONE;
            ST_DONE:                              state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_sig       = 1'b0;
        frame_done_sig = 1'b0;
        run_active     = 1'b0;
        start_frame    = 1'b0;
        case (state)
            ST_IDLE:  start_frame    = Start_sig;
            ST_RUN:   begin
                busy_sig   = 1'b1;
                run_active = 1'b1;
            end
            ST_DRAIN: busy_sig       = 1'b1;
            ST_DONE:  frame_done_sig = 1'b1;
            default:  ;
        endcase
    end

    assign fsm_state = state;

    // ---------------------------------------------------------- input side
    assign accept_pix = run_active && pix_valid_sig;
    assign last_pix   = (in_addr == LAST_ADDR);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign fifo_push  = accept_pix && (!fifo_full || fifo_pop);

    // in_addr advances on every accepted pulse, dropped or not, so a lost
    // pixel never shifts the rest of the frame. It stops at the last pixel.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            in_addr      <= '0;
            overflow_sig <= 1'b0;
        end else if (start_frame) begin
            in_addr      <= '0;
            overflow_sig <= 1'b0;
        end else if (accept_pix) begin
            if (!last_pix)              in_addr      <= in_addr + ADDR_W'(1);
            if (fifo_full && !fifo_pop) overflow_sig <= 1'b1;
        end
    end

    pix_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTn),
        .push      (fifo_push),
        .push_data ({in_addr, pix_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------------------------------------------------- write side
    assign wr_en    = !fifo_empty;
    assign fifo_pop = wr_en && wr_ready;
    // Zero the port when idle so reset leaves every output at 0.
    assign wr_addr  = fifo_empty ? '0 : fifo_head[ENTRY_W-1:PIX_W];
    assign wr_data  = fifo_empty ? '0 : fifo_head[PIX_W-1:0];

`ifdef MEDFILT_NOISE_STAT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            salt_cnt   <= '0;
            pepper_cnt <= '0;
        end else if (start_frame) begin
            salt_cnt   <= '0;
            pepper_cnt <= '0;
        end else if (fifo_pop) begin
            if ((&wr_data) && (salt_cnt != '1))
                salt_cnt <= salt_cnt + ADDR_W'(1);
            if ((wr_data == '0) && (pepper_cnt != '1))
                pepper_cnt <= pepper_cnt + ADDR_W'(1);
        end
    end
`else
    assign salt_cnt   = '0;
    assign pepper_cnt = '0;
`endif

endmodule

// File: tb/tb_medfilt_fb_writer.sv
// Bench for medfilt_fb_writer on a 4x4 frame with an 8-entry FIFO.
module tb_medfilt_fb_writer;

    localparam int NPIX  = 16;
    localparam int AW    = 18;
    localparam int PW    = 8;
    localparam int DEPTH = 8;
    localparam int EW    = AW + PW;
`ifdef MEDFILT_NOISE_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [PW-1:0] pdata = '0;
    logic          ready = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          busy_sig;
    logic          frame_done_sig;
    logic          overflow_sig;
    logic [AW-1:0] salt_cnt;
    logic [AW-1:0] pepper_cnt;
    logic [1:0]    fsm_state;

    medfilt_fb_writer #(
        .COLS(4), .ROWS(4), .ADDR_W(AW), .PIX_W(PW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK            (clk),
        .RSTn           (rst_n),
        .Start_sig      (start),
        .pix_valid_sig  (valid),
        .pix_data       (pdata),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (ready),
        .busy_sig       (busy_sig),
        .frame_done_sig (frame_done_sig),
        .overflow_sig   (overflow_sig),
        .salt_cnt       (salt_cnt),
        .pepper_cnt     (pepper_cnt),
        .fsm_state      (fsm_state)
    );

    // ------------------------------------------------ clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ scoreboard state
    int total = 0;
    int bad   = 0;

    // Reference model: frame phase 0=idle 1=capturing 2=draining 3=done,
    // and the pending writes in arrival order.
    logic [EW-1:0] exp_q[$];
    int            m_mode = 0;
    int            m_addr = 0;
    bit            m_ovf  = 1'b0;
    int            m_salt = 0;
    int            m_pep  = 0;

    int            wr_count[NPIX];
    logic [PW-1:0] wr_val[NPIX];
    logic [PW-1:0] sent[NPIX];
    int            done_cnt;
    int            stray_writes;
    int            n_writes;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode = 0;
        m_addr = 0;
        m_ovf  = 1'b0;
        m_salt = 0;
        m_pep  = 0;
    endtask

    // Effect of one rising edge on the model, from pre-edge values.
    task automatic model_edge(input logic s, input logic v, input logic [PW-1:0] d, input logic r);
        int            sz;
        bit            popped;
        logic [EW-1:0] item;
        sz     = exp_q.size();
        popped = (sz > 0) && r;
        if (popped) begin
            item = exp_q.pop_front();
            if (STAT_EN && item[PW-1:0] == 8'hFF) m_salt++;
            if (STAT_EN && item[PW-1:0] == 8'h00) m_pep++;
        end
        case (m_mode)
            0: if (s) begin
                m_mode = 1;
                m_addr = 0;
                m_ovf  = 1'b0;
                m_salt = 0;
                m_pep  = 0;
            end
            1: if (v) begin
                if (sz < DEPTH || popped) exp_q.push_back({AW'(m_addr), d});
                else                      m_ovf = 1'b1;
                if (m_addr == NPIX - 1) m_mode = 2;
                else                    m_addr++;
            end
            2: if (sz == 0) m_mode = 3;
            default: m_mode = 0;
        endcase
    endtask

    // One clock cycle: check outputs against the model, drive the inputs
    // for the coming edge, log any write that edge will complete.
    task automatic cycle(input logic s, input logic v, input logic [PW-1:0] d, input logic r);
        @(negedge clk);
        check("wr_en", wr_en, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("wr_addr", wr_addr, exp_q[0][EW-1:PW]);
            check("wr_data", wr_data, exp_q[0][PW-1:0]);
        end
        check("busy", busy_sig, (m_mode == 1) || (m_mode == 2));
        check("frame_done", frame_done_sig, m_mode == 3);
        check("overflow", overflow_sig, m_ovf);
        check("salt_cnt", salt_cnt, m_salt);
        check("pepper_cnt", pepper_cnt, m_pep);
        check("fsm_state", fsm_state, m_mode);
        if (frame_done_sig) done_cnt++;
        start = s;
        valid = v;
        pdata = d;
        ready = r;
        if (wr_en && r) begin
            n_writes++;
            if (wr_addr < NPIX) begin
                wr_count[wr_addr]++;
                wr_val[wr_addr] = wr_data;
            end else begin
                stray_writes++;
            end
        end
        model_edge(s, v, d, r);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NPIX; i++) begin
            wr_count[i] = 0;
            wr_val[i]   = '0;
            sent[i]     = '0;
        end
        done_cnt     = 0;
        stray_writes = 0;
        n_writes     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy_sig, 0);
        check({tag, "_frame_done"}, frame_done_sig, 0);
        check({tag, "_overflow"}, overflow_sig, 0);
        check({tag, "_salt"}, salt_cnt, 0);
        check({tag, "_pepper"}, pepper_cnt, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    function automatic logic [PW-1:0] frame_pix(input int kind, input int i);
        logic [PW-1:0] v;
        case (kind)
            3: begin
                if (i == 2 || i == 5 || i == 9) v = 8'hFF;
                else if (i == 4 || i == 13)     v = 8'h00;
                else                            v = 8'h40 + PW'(i);
            end
            4:       v = PW'($urandom_range(0, 255));
            5:       v = 8'h20 + PW'(i);
            default: v = 8'h10 + PW'(i);
        endcase
        return v;
    endfunction

    // kind 0: ready always high        kind 1: ready low for first 12 pulses
    // kind 2: ready toggles each cycle  kind 3: salt/pepper data
    // kind 4: random pulses and ready   kind 5: pulses before start and in drain
    task automatic run_frame(input int kind);
        int            pulses;
        int            cyc;
        logic          v;
        logic          r;
        logic [PW-1:0] d;
        clear_logs();
        if (kind == 5) for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        pulses = 0;
        cyc    = 0;
        while (pulses < NPIX && cyc < 400) begin
            case (kind)
                1:       begin v = 1'b1; r = (pulses >= 12); end
                2:       begin v = 1'b1; r = cyc[0]; end
                4:       begin v = ($urandom_range(0, 99) < 60); r = 1'($urandom_range(0, 1)); end
                default: begin v = 1'b1; r = 1'b1; end
            endcase
            d = frame_pix(kind, pulses);
            if (v) sent[pulses] = d;
            cycle(1'b0, v, d, r);
            if (v) pulses++;
            cyc++;
        end
        check("pulse_budget", pulses, NPIX);
        cyc = 0;
        while (!(m_mode == 0 && done_cnt > 0) && cyc < 200) begin
            v = (kind == 5) && (cyc < 4);
            case (kind)
                2:       r = cyc[0];
                4:       r = 1'($urandom_range(0, 1));
                5:       r = (cyc >= 4);
                default: r = 1'b1;
            endcase
            cycle(1'b0, v, 8'hEE, r);
            cyc++;
        end
        check("drain_budget", cyc < 200, 1);
    endtask

    typedef struct {
        int          kind;
        int          exp_writes;   // -1: decided by the model only
        logic [15:0] exp_mask;     // addresses that must be written once
        int          use_mask;
        int          exp_ovf;      // -1: decided by the model only
        int          exp_salt;
        int          exp_pep;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 16, 16'hFFFF, 1, 0, 0, 0};
        vecs[1] = '{1, 12, 16'hF0FF, 1, 1, 0, 0};
        vecs[2] = '{2, 16, 16'hFFFF, 1, 0, 0, 0};
        vecs[3] = '{3, 16, 16'hFFFF, 1, 0, STAT_EN ? 3 : 0, STAT_EN ? 2 : 0};
        vecs[4] = '{4, -1, 16'h0000, 0, -1, -1, -1};
        vecs[5] = '{5, 16, 16'hFFFF, 1, 0, 0, 0};
        vecs[6] = '{4, -1, 16'h0000, 0, -1, -1, -1};

        // reset state
        clear_logs();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h77, 1'b1);
        check("idle_no_write", n_writes, 0);

        for (int t = 0; t < 7; t++) begin
            run_frame(vecs[t].kind);
            check("done_pulses", done_cnt, 1);
            check("stray_writes", stray_writes, 0);
            if (vecs[t].exp_writes >= 0) check("n_writes", n_writes, vecs[t].exp_writes);
            if (vecs[t].exp_ovf >= 0)    check("frame_ovf", overflow_sig, vecs[t].exp_ovf);
            if (vecs[t].exp_salt >= 0) begin
                check("frame_salt", salt_cnt, vecs[t].exp_salt);
                check("frame_pepper", pepper_cnt, vecs[t].exp_pep);
            end
            for (int a = 0; a < NPIX; a++) begin
                if (vecs[t].use_mask != 0) check("addr_written", wr_count[a], vecs[t].exp_mask[a]);
                else                       check("addr_once", wr_count[a] <= 1, 1);
                if (wr_count[a] == 1) check("addr_value", wr_val[a], sent[a]);
            end
            cycle(1'b0, 1'b0, '0, 1'b1);
        end

        // reset in the middle of a frame with writes pending
        clear_logs();
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h50 + PW'(i), 1'b0);
        @(negedge clk);
        valid = 1'b0;
        check("pre_rst_wr_en", wr_en, 1);
        check("pre_rst_busy", busy_sig, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold_done", frame_done_sig, 0);
            check("rst_hold_wr_en", wr_en, 0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check("rst_no_done", done_cnt, 0);
        check("rst_no_write", n_writes, 0);

        // restart after the mid-frame reset
        run_frame(0);
        check("restart_done", done_cnt, 1);
        check("restart_writes", n_writes, 16);
        for (int a = 0; a < NPIX; a++) begin
            check("restart_written", wr_count[a], 1);
            check("restart_value", wr_val[a], sent[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
